// File: rtl/ppg_ma_filter.sv
// ppg_ma_filter: per-LED 16-sample moving-average DC estimate and AC residual,
// both channels sharing one add/subtract path sequenced by a small FSM.
module ppg_ma_filter #(
  parameter int DW     = 22,
  parameter int LOG2_N = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          new_samples,
  input  logic [DW-1:0] led_one,
  input  logic [DW-1:0] led_two,
  output logic          out_valid,
  output logic [DW-1:0] dc_one,
  output logic [DW-1:0] dc_two,
  output logic [DW:0]   ac_one,
  output logic [DW:0]   ac_two,
  output logic          primed,
  output logic          overrun
);
  localparam int N  = 1 << LOG2_N;
  localparam int SW = DW + LOG2_N;
  localparam logic [LOG2_N:0] NCNT = (LOG2_N+1)'(N);
  typedef enum logic [1:0] {IDLE, UPD1, UPD2, OUT} state_t;
  state_t          r_st;
  logic [DW-1:0]   r_s1, r_s2;
  logic [SW-1:0]   r_sum1, r_sum2;
  logic [DW-1:0]   r_h1 [N];
  logic [DW-1:0]   r_h2 [N];
  logic [LOG2_N-1:0] r_ptr;
  logic [LOG2_N:0] r_cnt;
  logic [SW-1:0]   w_sum_nx;
  logic [LOG2_N:0] w_cnt_nx;
  logic [DW-1:0]   w_dc1, w_dc2;
  // The sum already contains the evicted sample, so the subtraction never underflows.
  always_comb begin
    w_sum_nx = (r_st == UPD1) ? r_sum1 + SW'(r_s1) - SW'(r_h1[r_ptr])
                              : r_sum2 + SW'(r_s2) - SW'(r_h2[r_ptr]);
    w_cnt_nx = (r_cnt == NCNT) ? r_cnt : r_cnt + 1'b1;
    w_dc1    = DW'(r_sum1 >> LOG2_N);
    w_dc2    = DW'(r_sum2 >> LOG2_N);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st      <= IDLE;
      r_s1      <= '0;
      r_s2      <= '0;
      r_sum1    <= '0;
      r_sum2    <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      dc_one    <= '0;
      dc_two    <= '0;
      ac_one    <= '0;
      ac_two    <= '0;
      primed    <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_h1[i] <= '0;
        r_h2[i] <= '0;
      end
    end else if (clear) begin
      r_st      <= IDLE;
      r_sum1    <= '0;
      r_sum2    <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_h1[i] <= '0;
        r_h2[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (new_samples && r_st != IDLE) overrun <= 1'b1;
      case (r_st)
        IDLE: if (new_samples) begin
          r_s1 <= led_one;
          r_s2 <= led_two;
          r_st <= UPD1;
        end
        UPD1: begin
          r_sum1      <= w_sum_nx;
          r_h1[r_ptr] <= r_s1;
          r_st        <= UPD2;
        end
        UPD2: begin
          r_sum2      <= w_sum_nx;
          r_h2[r_ptr] <= r_s2;
          r_st        <= OUT;
        end
        OUT: begin
          r_ptr  <= r_ptr + 1'b1;
          r_cnt  <= w_cnt_nx;
          primed <= (w_cnt_nx == NCNT);
          if (w_cnt_nx == NCNT) begin
            dc_one    <= w_dc1;
            dc_two    <= w_dc2;
            ac_one    <= {1'b0, r_s1} - {1'b0, w_dc1};
            ac_two    <= {1'b0, r_s2} - {1'b0, w_dc2};
            out_valid <= 1'b1;
          end
          r_st <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ppg_ma_filter.sv
// tb_ppg_ma_filter: scoreboard bench for ppg_ma_filter against a sliding-window
// queue model; expected results are queued at acceptance and popped on out_valid.
module tb_ppg_ma_filter;
  logic        clk = 0, reset_n = 0, clear = 0, new_samples = 0;
  logic [21:0] led_one = 0, led_two = 0;
  logic        out_valid, primed, overrun;
  logic [21:0] dc_one, dc_two;
  logic [22:0] ac_one, ac_two;

  ppg_ma_filter dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .new_samples(new_samples),
    .led_one(led_one), .led_two(led_two), .out_valid(out_valid),
    .dc_one(dc_one), .dc_two(dc_two), .ac_one(ac_one), .ac_two(ac_two),
    .primed(primed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [21:0] d1, d2;
    logic [22:0] a1, a2;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          errors = 0, checks = 0, ncyc = 0, last_acc = -100, cnt = 0;
  bit          ov_exp = 0, want;
  logic [21:0] w1[$], w2[$];
  logic [21:0] hd1 = 0, hd2 = 0;
  logic [22:0] ha1 = 0, ha2 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [21:0] mean(input logic [21:0] w[$]);
    longint s = 0;
    foreach (w[i]) s += w[i];
    return 22'(s / 16);
  endfunction

  task automatic mreset(input bit hard);
    q.delete();
    w1.delete();
    w2.delete();
    for (int i = 0; i < 16; i++) begin
      w1.push_back(0);
      w2.push_back(0);
    end
    cnt = 0;
    last_acc = -100;
    ov_exp = 0;
    if (hard) begin
      hd1 = 0; hd2 = 0; ha1 = 0; ha2 = 0;
    end
  endtask

  task automatic model(input logic [21:0] a, input logic [21:0] b, input int edge_n);
    w1.push_back(a);
    void'(w1.pop_front());
    w2.push_back(b);
    void'(w2.pop_front());
    if (cnt < 16) cnt++;
    if (cnt == 16) begin
      hd1 = mean(w1);
      hd2 = mean(w2);
      ha1 = {1'b0, a} - {1'b0, hd1};
      ha2 = {1'b0, b} - {1'b0, hd2};
      q.push_back('{edge_n + 3, hd1, hd2, ha1, ha2});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Acceptance is decided purely by spacing: at least 4 edges since the last accepted one.
  task automatic strobe(input logic [21:0] a, input logic [21:0] b);
    int en = ncyc + 1;
    new_samples = 1;
    led_one = a;
    led_two = b;
    if (en - last_acc >= 4) begin
      last_acc = en;
      model(a, b, en);
    end else ov_exp = 1;
    @(posedge clk);
    #1 new_samples = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dc", {dc_one, dc_two}, 0);
    chk("rst_ac", {ac_one, ac_two}, 0);
    chk("rst_flags", {primed, overrun}, 0);
    mreset(1);
    @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk);
    #1 clear = 0;
    mreset(0);
  endtask

  task automatic settle();
    idle(8);
    chk("primed", primed, cnt == 16);
    chk("overrun", overrun, ov_exp);
    chk("dc_one", dc_one, hd1);
    chk("dc_two", dc_two, hd2);
    chk("ac_one", ac_one, ha1);
    chk("ac_two", ac_two, ha2);
  endtask

  task automatic fill(input logic [21:0] v);
    for (int i = 0; i < 16; i++) begin
      strobe(v, v);
      idle(7);
    end
  endtask

  always @(posedge clk) ncyc++;

  always @(negedge clk) if (reset_n) begin
    want = q.size() > 0 && q[0].due == ncyc;
    if (out_valid || want) begin
      chk("out_valid_timing", out_valid, want);
      if (want) begin
        e = q.pop_front();
        if (out_valid) begin
          chk("sb_dc_one", dc_one, e.d1);
          chk("sb_dc_two", dc_two, e.d2);
          chk("sb_ac_one", ac_one, e.a1);
          chk("sb_ac_two", ac_two, e.a2);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    fill(1000);
    settle();
    chk("t1_dc_one", dc_one, 1000);
    chk("t1_ac_one", ac_one, 0);
    chk("t1_primed", primed, 1);
    strobe(2600, 1000);
    settle();
    chk("t2_dc_one", dc_one, 1100);
    chk("t2_ac_one", ac_one, 1500);
    chk("t2_dc_two", dc_two, 1000);
    chk("t2_ac_two", ac_two, 0);
    do_reset();
    fill(1000);
    strobe(0, 1000);
    settle();
    chk("t3_dc_one", dc_one, 937);
    chk("t3_ac_one", ac_one, 23'h7FFC57);
    do_reset();
    fill(22'h3FFFFF);
    settle();
    chk("t4_dc_max", dc_one, 22'h3FFFFF);
    chk("t4_ac_max", ac_one, 0);
    strobe(0, 0);
    settle();
    chk("t4_dc_one_17", dc_one, 22'h3BFFFF);
    chk("t4_dc_two_17", dc_two, 22'h3BFFFF);
    strobe(5, 6);
    idle(1);
    strobe(7, 8);
    settle();
    chk("t5_overrun", overrun, 1);
    do_clear();
    settle();
    chk("t5_clr_primed", primed, 0);
    for (int i = 0; i < 15; i++) begin
      strobe(22'($urandom), 22'($urandom));
      idle(4);
    end
    settle();
    chk("t5_not_primed", primed, 0);
    strobe(22'($urandom), 22'($urandom));
    settle();
    chk("t5_primed", primed, 1);
    strobe(22'($urandom), 22'($urandom));
    idle(1);
    do_reset();
    chk("t6_flags", {primed, overrun}, 0);
    for (int i = 0; i < 16; i++) begin
      strobe(22'($urandom), 22'($urandom));
      idle($urandom_range(3, 6));
    end
    settle();
    chk("t6_primed", primed, 1);
    for (int i = 0; i < 200; i++) begin
      strobe(22'($urandom), 22'($urandom));
      idle($urandom_range(0, 6));
    end
    settle();
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
